// File: rtl/mpc_tg_pkg.sv
// Traffic generator shared types: channel state, address and data pattern helpers.
package mpc_tg_pkg;

   localparam int unsigned TG_MAX_DATA     = 1024;
   localparam int unsigned TG_MAX_CHANNELS = 8;

   typedef enum logic [2:0] {
      TG_IDLE,
      TG_ISSUE_ST,
      TG_ISSUE_LD,
      TG_WAIT_RSP,
      TG_DONE
   } tg_state_e;

   // Byte address of op i on channel c; caller truncates to the bus width.
   function automatic logic [63:0] tg_addr(input logic [7:0]  c,
                                           input logic [8:0]  i,
                                           input logic [63:0] base,
                                           input logic [63:0] chan_stride,
                                           input logic [63:0] addr_stride);
      return base + 64'(c) * chan_stride + 64'(i) * addr_stride;
   endfunction

   // dw/32 copies of {c, i, addr[15:0]}; caller truncates to dw bits.
   function automatic logic [TG_MAX_DATA-1:0] tg_pattern(input logic [7:0]  c,
                                                         input logic [7:0]  i,
                                                         input logic [15:0] addr,
                                                         input int unsigned dw);
      logic [TG_MAX_DATA-1:0] p;
      p = '0;
      for (int unsigned k = 0; k < TG_MAX_DATA / 32; k++) begin
         if (k < dw / 32) p[k*32 +: 32] = {c, i, addr};
      end
      return p;
   endfunction

endpackage

// File: rtl/mpc_types.sv
// Shared request op encodings for the multi-port cache wrapper.
package mpc_types;

   localparam logic [2:0] MPC_OP_LOAD  = 3'd1;
   localparam logic [2:0] MPC_OP_STORE = 3'd2;

endpackage

// File: rtl/mpc_traffic_gen_if.sv
// Per-channel request/response bus between the traffic generator and the cache wrapper.
interface mpc_traffic_gen_if #(
   parameter int unsigned NumChannels = 3,
   parameter int unsigned OpWidth     = 3,
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned DataWidth   = 128
);

   logic [NumChannels-1:0]                req_valid;
   logic [NumChannels-1:0]                req_ready;
   logic [NumChannels-1:0][OpWidth-1:0]   req_op;
   logic [NumChannels-1:0][AddrWidth-1:0] req_addr;
   logic [NumChannels-1:0][DataWidth-1:0] req_wdata;
   logic [NumChannels-1:0]                rsp_valid;
   logic [NumChannels-1:0]                rsp_ready;
   logic [NumChannels-1:0][DataWidth-1:0] rsp_rdata;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/mpc_tg_channel.sv
// One traffic generator channel: store/load sequencer plus load data checker.
// Optional response watchdog enabled by MPC_TG_TIMEOUT_EN.
module mpc_tg_channel
   import mpc_tg_pkg::*;
   import mpc_types::*;
#(
   parameter int unsigned Chan          = 0,
   parameter int unsigned OpWidth       = 3,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 128,
   parameter int unsigned NumOps        = 16,
   parameter logic [31:0] BaseAddr      = 32'h0000_00A0,
   parameter int unsigned AddrStride    = 16,
   parameter logic [31:0] ChanStride    = 32'h0001_0000,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mode,
   output logic                 req_valid,
   input  logic                 req_ready,
   output logic [OpWidth-1:0]   req_op,
   output logic [AddrWidth-1:0] req_addr,
   output logic [DataWidth-1:0] req_wdata,
   input  logic                 rsp_valid,
   output logic                 rsp_ready,
   input  logic [DataWidth-1:0] rsp_rdata,
   output logic                 err,
   output logic                 done_c
`ifdef MPC_TG_TIMEOUT_EN
   ,
   output logic                 timeout
`endif
);

   localparam int unsigned            IdxW    = $clog2(NumOps) + 1;
   localparam logic [IdxW-1:0]        LastIdx = IdxW'(NumOps - 1);
   localparam logic [OpWidth-1:0]     OpSt    = OpWidth'(MPC_OP_STORE);
   localparam logic [OpWidth-1:0]     OpLd    = OpWidth'(MPC_OP_LOAD);
   localparam logic [AddrWidth-1:0]   Addr0   = AddrWidth'(tg_addr(8'(Chan), 9'd0, 64'(BaseAddr),
                                                                   64'(ChanStride), 64'(AddrStride)));
   localparam logic [DataWidth-1:0]   Pat0    = DataWidth'(tg_pattern(8'(Chan), 8'd0, 16'(Addr0),
                                                                      DataWidth));

   tg_state_e              state;
   logic [IdxW-1:0]        idx;
   logic                   mode_q;
   logic [IdxW-1:0]        nxt_idx;
   logic [15:0]            cur_lo;
   logic [AddrWidth-1:0]   nxt_addr;
   logic [DataWidth-1:0]   nxt_pat;
   logic [DataWidth-1:0]   exp_data;
   logic                   last_c;

   // Address/pattern for the current and the following op index.
   always_comb begin
      nxt_idx  = idx + IdxW'(1);
      cur_lo   = 16'(tg_addr(8'(Chan), 9'(idx), 64'(BaseAddr), 64'(ChanStride), 64'(AddrStride)));
      nxt_addr = AddrWidth'(tg_addr(8'(Chan), 9'(nxt_idx), 64'(BaseAddr), 64'(ChanStride),
                                    64'(AddrStride)));
      exp_data = DataWidth'(tg_pattern(8'(Chan), 8'(idx), cur_lo, DataWidth));
      nxt_pat  = DataWidth'(tg_pattern(8'(Chan), 8'(nxt_idx), 16'(nxt_addr), DataWidth));
   end

   assign last_c = (idx == LastIdx);
   assign done_c = (state == TG_DONE);

`ifdef MPC_TG_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
   logic [TmoW-1:0] tmo_cnt;
   logic            tmo_hit_c;

   assign tmo_hit_c = (tmo_cnt == TmoW'(TimeoutCycles - 1));

   // Response watchdog: counts cycles spent waiting for a load response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state == TG_WAIT_RSP && !rsp_valid && !tmo_hit_c) begin
         tmo_cnt <= tmo_cnt + TmoW'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end
`else
   logic [31:0] unused_tmo;
   assign unused_tmo = 32'(TimeoutCycles);
`endif

   // Channel sequencer with registered request, checker and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= TG_IDLE;
         idx       <= '0;
         mode_q    <= 1'b0;
         req_valid <= 1'b0;
         req_op    <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
         rsp_ready <= 1'b0;
         err       <= 1'b0;
`ifdef MPC_TG_TIMEOUT_EN
         timeout   <= 1'b0;
`endif
      end else begin
         rsp_ready <= 1'b1;
         err       <= 1'b0;
         case (state)
            TG_IDLE, TG_DONE: begin
               err <= rsp_valid;
               if (start) begin
                  state     <= TG_ISSUE_ST;
                  idx       <= '0;
                  mode_q    <= mode;
                  req_valid <= 1'b1;
                  req_op    <= OpSt;
                  req_addr  <= Addr0;
                  req_wdata <= Pat0;
`ifdef MPC_TG_TIMEOUT_EN
                  timeout   <= 1'b0;
`endif
               end
            end
            TG_ISSUE_ST: begin
               err <= rsp_valid;
               if (req_ready) begin
                  if (!mode_q) begin
                     state     <= TG_ISSUE_LD;
                     req_op    <= OpLd;
                     req_wdata <= '0;
                  end else if (last_c) begin
                     state     <= TG_ISSUE_LD;
                     idx       <= '0;
                     req_op    <= OpLd;
                     req_addr  <= Addr0;
                     req_wdata <= '0;
                  end else begin
                     idx       <= nxt_idx;
                     req_addr  <= nxt_addr;
                     req_wdata <= nxt_pat;
                  end
               end
            end
            TG_ISSUE_LD: begin
               err <= rsp_valid;
               if (req_ready) begin
                  state     <= TG_WAIT_RSP;
                  req_valid <= 1'b0;
               end
            end
            TG_WAIT_RSP: begin
               if (rsp_valid) begin
                  err <= (rsp_rdata != exp_data);
                  if (last_c) begin
                     state <= TG_DONE;
                  end else begin
                     idx       <= nxt_idx;
                     req_valid <= 1'b1;
                     req_addr  <= nxt_addr;
                     if (mode_q) begin
                        state     <= TG_ISSUE_LD;
                        req_op    <= OpLd;
                        req_wdata <= '0;
                     end else begin
                        state     <= TG_ISSUE_ST;
                        req_op    <= OpSt;
                        req_wdata <= nxt_pat;
                     end
                  end
               end
`ifdef MPC_TG_TIMEOUT_EN
               else if (tmo_hit_c) begin
                  err     <= 1'b1;
                  timeout <= 1'b1;
                  state   <= TG_DONE;
               end
`endif
            end
            default: begin
               state     <= TG_IDLE;
               req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mpc_traffic_gen.sv
// Multi-channel store/load traffic generator and checker for the multi-port cache wrapper.
// Optional per-channel response watchdog and timeout output enabled by MPC_TG_TIMEOUT_EN.
module mpc_traffic_gen
   import mpc_tg_pkg::*;
#(
   parameter int unsigned NumChannels   = 3,
   parameter int unsigned OpWidth       = 3,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 128,
   parameter int unsigned NumOps        = 16,
   parameter logic [31:0] BaseAddr      = 32'h0000_00A0,
   parameter int unsigned AddrStride    = 16,
   parameter logic [31:0] ChanStride    = 32'h0001_0000,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   mode,
   mpc_traffic_gen_if.master      bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [15:0]            err_count
`ifdef MPC_TG_TIMEOUT_EN
   ,
   output logic [NumChannels-1:0] timeout
`endif
);

   localparam int unsigned SumW = $clog2(TG_MAX_CHANNELS + 1);

   logic [NumChannels-1:0]                req_valid;
   logic [NumChannels-1:0][OpWidth-1:0]   req_op;
   logic [NumChannels-1:0][AddrWidth-1:0] req_addr;
   logic [NumChannels-1:0][DataWidth-1:0] req_wdata;
   logic [NumChannels-1:0]                rsp_ready;
   logic [NumChannels-1:0]                err_pulse;
   logic [NumChannels-1:0]                chan_done_c;

   logic              start_acc_c;
   logic [SumW-1:0]   err_sum_c;
   logic [16:0]       cnt_sum_c;
   logic [15:0]       cnt_next_c;
   logic              done_next_c;

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      mpc_tg_channel #(
         .Chan          (c),
         .OpWidth       (OpWidth),
         .AddrWidth     (AddrWidth),
         .DataWidth     (DataWidth),
         .NumOps        (NumOps),
         .BaseAddr      (BaseAddr),
         .AddrStride    (AddrStride),
         .ChanStride    (ChanStride),
         .TimeoutCycles (TimeoutCycles)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start_acc_c),
         .mode      (mode),
         .req_valid (req_valid[c]),
         .req_ready (bus.req_ready[c]),
         .req_op    (req_op[c]),
         .req_addr  (req_addr[c]),
         .req_wdata (req_wdata[c]),
         .rsp_valid (bus.rsp_valid[c]),
         .rsp_ready (rsp_ready[c]),
         .rsp_rdata (bus.rsp_rdata[c]),
         .err       (err_pulse[c]),
         .done_c    (chan_done_c[c])
`ifdef MPC_TG_TIMEOUT_EN
         ,
         .timeout   (timeout[c])
`endif
      );
   end

   assign bus.req_valid = req_valid;
   assign bus.req_op    = req_op;
   assign bus.req_addr  = req_addr;
   assign bus.req_wdata = req_wdata;
   assign bus.rsp_ready = rsp_ready;

   // Start acceptance, per-cycle error total with saturation, and run completion.
   always_comb begin
      start_acc_c = start && !busy;
      err_sum_c   = '0;
      for (int unsigned c = 0; c < NumChannels; c++) begin
         err_sum_c = err_sum_c + SumW'(err_pulse[c]);
      end
      cnt_sum_c   = 17'(err_count) + 17'(err_sum_c);
      if (start_acc_c) begin
         cnt_next_c  = '0;
         done_next_c = 1'b0;
      end else begin
         cnt_next_c  = cnt_sum_c[16] ? 16'hFFFF : cnt_sum_c[15:0];
         done_next_c = done || (busy && (&chan_done_c));
      end
   end

   // Run status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
      end else begin
         busy      <= start_acc_c || (busy && !(&chan_done_c));
         done      <= done_next_c;
         pass      <= done_next_c && (cnt_next_c == 16'h0000);
         err_count <= cnt_next_c;
      end
   end

endmodule

// File: tb/tb_mpc_traffic_gen.sv
// Scoreboard bench for mpc_traffic_gen: memory model with 2-cycle load latency,
// expected request streams queued per channel and checked by a monitor.
module tb_mpc_traffic_gen;
   import mpc_types::*;

   localparam int unsigned NCH  = 3;
   localparam int unsigned NOPS = 16;

   typedef struct packed {
      logic [2:0]   op;
      logic [31:0]  addr;
      logic [127:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        busy, done, pass;
   logic [15:0] err_count;
`ifdef MPC_TG_TIMEOUT_EN
   logic [NCH-1:0] timeout;
`endif

   mpc_traffic_gen_if #(.NumChannels(NCH), .OpWidth(3), .AddrWidth(32), .DataWidth(128)) bus ();

   mpc_traffic_gen #(
      .NumChannels(NCH), .OpWidth(3), .AddrWidth(32), .DataWidth(128), .NumOps(NOPS),
      .BaseAddr(32'h0000_00A0), .AddrStride(16), .ChanStride(32'h0001_0000), .TimeoutCycles(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bus(bus),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef MPC_TG_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   req_t exp_q[NCH][$];
   logic [127:0] mem [logic [31:0]];
   bit           pend[NCH];
   int           due[NCH];
   logic [127:0] pdata[NCH];
   int           cyc = 0;
   bit           stall_en = 0, corrupt_en = 0, inject_arm = 0;
   bit           held[NCH];
   req_t         hold_v[NCH];
   req_t         first0[2];
   int           n0 = 0;
   int           st2 = 0;
   req_t         st2_last;
   bit           seen_op7 = 0;

   function automatic logic [31:0] m_addr(input int c, input int i);
      return 32'h0000_00A0 + 32'(c) * 32'h0001_0000 + 32'(i) * 32'd16;
   endfunction

   function automatic logic [127:0] m_wdata(input int c, input int i);
      logic [31:0] a;
      logic [31:0] w;
      a = m_addr(c, i);
      w = {8'(c), 8'(i), a[15:0]};
      return {4{w}};
   endfunction

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory model / response driver: updates after each rising edge.
   always begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      for (int c = 0; c < NCH; c++) begin
         bus.rsp_valid[c] = 1'b0;
         bus.req_ready[c] = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rst_n && pend[c] && due[c] == cyc) begin
            bus.rsp_valid[c] = 1'b1;
            bus.rsp_rdata[c] = pdata[c];
            pend[c] = 1'b0;
         end
      end
      if (rst_n && inject_arm && bus.req_valid[2] && bus.req_op[2] == MPC_OP_STORE
          && !pend[2] && !bus.rsp_valid[2]) begin
         bus.rsp_valid[2] = 1'b1;
         bus.rsp_rdata[2] = '0;
         inject_arm = 0;
      end
   end

   // Monitor: checks every transfer against the scoreboard and request stability in stalls.
   always @(negedge clk) begin : mon
      req_t         cur;
      logic [127:0] d;
      if (rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            cur = {bus.req_op[c], bus.req_addr[c], bus.req_wdata[c]};
            if (held[c]) begin
               chk($sformatf("stall_hold_ch%0d", c), {bus.req_valid[c], cur}, {1'b1, hold_v[c]});
               held[c] = 0;
            end
            if (bus.req_valid[c] && bus.req_ready[c]) begin
               if (exp_q[c].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_req_ch%0d: got %0h expected none", c, cur);
               end else begin
                  chk($sformatf("req_ch%0d", c), cur, exp_q[c].pop_front());
               end
               if (cur.op == MPC_OP_STORE) begin
                  mem[cur.addr] = cur.wdata;
               end else begin
                  d = mem.exists(cur.addr) ? mem[cur.addr] : '0;
                  if (corrupt_en && c == 1 && cur.addr == m_addr(1, 5)) d[0] = ~d[0];
                  pend[c]  = 1'b1;
                  due[c]   = cyc + 2;
                  pdata[c] = d;
               end
               if (c == 0 && n0 < 2) first0[n0] = cur;
               if (c == 0) n0++;
               if (c == 2 && cur.op == MPC_OP_STORE) begin
                  st2++;
                  if (st2 == NOPS) st2_last = cur;
               end
               if (c == 0 && cur.addr == m_addr(0, 7)) seen_op7 = 1;
            end else if (bus.req_valid[c]) begin
               held[c]   = 1;
               hold_v[c] = cur;
            end
         end
      end
   end

   task automatic clear_model();
      for (int c = 0; c < NCH; c++) begin
         exp_q[c].delete();
         pend[c] = 0;
         held[c] = 0;
      end
      mem.delete();
      n0 = 0;
      st2 = 0;
      seen_op7 = 0;
   endtask

   task automatic start_run(input bit m, input bit stall, input bit corrupt, input bit inject);
      clear_model();
      for (int c = 0; c < NCH; c++) begin
         if (!m) begin
            for (int i = 0; i < NOPS; i++) begin
               exp_q[c].push_back({MPC_OP_STORE, m_addr(c, i), m_wdata(c, i)});
               exp_q[c].push_back({MPC_OP_LOAD, m_addr(c, i), 128'h0});
            end
         end else begin
            for (int i = 0; i < NOPS; i++)
               exp_q[c].push_back({MPC_OP_STORE, m_addr(c, i), m_wdata(c, i)});
            for (int i = 0; i < NOPS; i++)
               exp_q[c].push_back({MPC_OP_LOAD, m_addr(c, i), 128'h0});
         end
      end
      stall_en   = stall;
      corrupt_en = corrupt;
      inject_arm = inject;
      @(posedge clk); #1;
      mode  = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = ~m;
      chk("req_valid_rise", {busy, bus.req_valid}, {1'b1, 3'b111});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_req_valid", bus.req_valid, 3'b000);
      chk("reset_status", {busy, done, pass, err_count}, 19'h0);
      chk("reset_ch0_addr", bus.req_addr[0], 32'h0);
      clear_model();
      stall_en = 0;
      inject_arm = 0;
      bus.rsp_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic finish_run(input string name, input int exp_err);
      int n;
      int left;
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      stall_en = 0;
      chk({"done_", name}, done, 1'b1);
      chk({"result_", name}, {busy, pass, err_count}, {1'b0, exp_err == 0, 16'(exp_err)});
      left = 0;
      for (int c = 0; c < NCH; c++) left += exp_q[c].size();
      chk({"drain_", name}, left, 0);
      repeat (3) @(posedge clk);
      #1;
      chk({"done_sticky_", name}, {done, busy}, 2'b10);
      if (!done) do_reset();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int n;
      bus.req_ready = '1;
      bus.rsp_valid = '0;
      bus.rsp_rdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_req_valid", bus.req_valid, 3'b000);
      chk("reset_rsp_ready", bus.rsp_ready, 3'b000);
      chk("reset_status", {busy, done, pass, err_count}, 19'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rsp_ready_const", bus.rsp_ready, 3'b111);

      // Interleaved, always ready.
      start_run(1'b0, 1'b0, 1'b0, 1'b0);
      finish_run("interleaved", 0);
      chk("ch0_op0_store", first0[0], {MPC_OP_STORE, 32'h0000_00A0, {4{32'h0000_00A0}}});
      chk("ch0_op0_load", first0[1], {MPC_OP_LOAD, 32'h0000_00A0, 128'h0});
      chk("ch2_op15_store", st2_last, {MPC_OP_STORE, 32'h0002_0190, {4{32'h020F_0190}}});

      // Burst with random ready stalls; a start during the run must be ignored.
      start_run(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      start = 1'b1;
      mode  = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_during_run", busy, 1'b1);
      finish_run("burst_stall", 0);

      // Corrupted load data on channel 1, op 5.
      start_run(1'b0, 1'b0, 1'b1, 1'b0);
      finish_run("corrupt", 1);
      corrupt_en = 0;

      // Unexpected response on channel 2 while it issues a store.
      start_run(1'b0, 1'b0, 1'b0, 1'b1);
      finish_run("inject", 1);

      // Reset in the middle of a run, then a fresh run from op 0.
      start_run(1'b0, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (!seen_op7 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_op7", seen_op7, 1'b1);
      #2;
      do_reset();
      start_run(1'b0, 1'b0, 1'b0, 1'b0);
      finish_run("after_reset", 0);
      chk("restart_op0", first0[0], {MPC_OP_STORE, 32'h0000_00A0, {4{32'h0000_00A0}}});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
